// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants for the uart receiver, transmitter and loopback controller
package uart_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_CLK_HZ     = 50_000_000;
  localparam int DEFAULT_BAUD       = 115_200;
  localparam int CLKS_PER_BIT       = DEFAULT_CLK_HZ / DEFAULT_BAUD;

  // One-hot loopback controller states
  localparam logic [4:0] ST_IDLE      = 5'b00001;
  localparam logic [4:0] ST_START     = 5'b00010;
  localparam logic [4:0] ST_WAIT_BUSY = 5'b00100;
  localparam logic [4:0] ST_WAIT_DONE = 5'b01000;
  localparam logic [4:0] ST_GAP       = 5'b10000;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous byte fifo with combinational head read
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          sysclk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         push_data,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         head,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  // A full fifo still accepts a byte when the head leaves in the same cycle
  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage write; old head is read before the edge so push-on-full with pop is safe
  always_ff @(posedge sysclk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at FIFO_DEPTH (power of two); count tracks occupancy
  always_ff @(posedge sysclk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_loop_ctrl.sv
// rtl/uart_loop_ctrl.sv - buffers received bytes and relaunches them through the transmitter
module uart_loop_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH  = 16,
  parameter int GAP_CYCLES  = 0,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                        sysclk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [DATA_WIDTH-1:0]       rx_data,
  input  logic                        rx_data_valid,
  output logic [DATA_WIDTH-1:0]       tx_data,
  output logic                        tx_start,
  input  logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        tx_timeout,
  input  logic                        clear_err
);

  localparam int TW = $clog2(ACK_TIMEOUT) + 1;
  localparam int GW = $clog2(GAP_CYCLES + 2);
  // Counter value one short of ACK_TIMEOUT-1: the increment out of it is the timeout
  localparam logic [TW-1:0] TO_PRE   = TW'(ACK_TIMEOUT - 2);
  // GAP always lasts at least one cycle, so a zero gap shares the single-cycle path
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  logic [4:0]            state;
  logic [TW-1:0]         to_cnt;
  logic [GW-1:0]         gap_cnt;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic                  overflow_set;
  logic                  timeout_set;

  assign pop          = (state == ST_IDLE) && enable && !fifo_empty;
  assign overflow_set = rx_data_valid && fifo_full && !pop;
  assign timeout_set  = (state == ST_WAIT_BUSY) && !tx_busy && (to_cnt == TO_PRE);

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sysclk    (sysclk),
    .rst       (rst),
    .push      (rx_data_valid),
    .push_data (rx_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Launch sequencer: pop, pulse tx_start, wait for busy to rise and fall, then gap
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state    <= ST_IDLE;
      tx_data  <= '0;
      tx_start <= 1'b0;
      to_cnt   <= '0;
      gap_cnt  <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            tx_data  <= fifo_head;
            tx_start <= 1'b1;
            state    <= ST_START;
          end
        end
        ST_START: begin
          to_cnt <= '0;
          state  <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (tx_busy) begin
            state <= ST_WAIT_DONE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
            if (to_cnt == TO_PRE) begin
              gap_cnt <= '0;
              state   <= ST_GAP;
            end
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) begin
            gap_cnt <= '0;
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky error flags; a set event in the same cycle as clear_err wins
  always_ff @(posedge sysclk) begin
    if (rst) begin
      overflow   <= 1'b0;
      tx_timeout <= 1'b0;
    end else begin
      overflow   <= overflow_set | (overflow & ~clear_err);
      tx_timeout <= timeout_set | (tx_timeout & ~clear_err);
    end
  end

endmodule

// File: tb/tb_uart_loop_ctrl.sv
// tb/tb_uart_loop_ctrl.sv - self-checking bench for uart_loop_ctrl
module tb_uart_loop_ctrl;

  localparam int GAP = 4;
  localparam int ACK = 16;

  logic       sysclk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy = 1'b0;
  logic [4:0] fifo_count;
  logic       overflow;
  logic       tx_timeout;
  logic       clear_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  bit model_on = 1'b0;
  int busy_len = 20;
  int busy_left = 0;

  int         cyc = 0;
  int         fall_cyc = 0;
  logic       busy_q = 1'b0;
  int         start_cyc[$];
  logic [7:0] start_data[$];
  int         start_gap[$];

  typedef struct {
    logic       vld;
    logic [7:0] din;
    logic       en;
    logic       clr;
    int         exp_cnt;
    logic       exp_ovf;
    logic       exp_start;
  } vec_t;
  vec_t vt[20];

  always #5 sysclk = ~sysclk;

  uart_loop_ctrl #(
    .DATA_WIDTH  (8),
    .FIFO_DEPTH  (16),
    .GAP_CYCLES  (GAP),
    .ACK_TIMEOUT (ACK)
  ) dut (
    .sysclk        (sysclk),
    .rst           (rst),
    .enable        (enable),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .tx_data       (tx_data),
    .tx_start      (tx_start),
    .tx_busy       (tx_busy),
    .fifo_count    (fifo_count),
    .overflow      (overflow),
    .tx_timeout    (tx_timeout),
    .clear_err     (clear_err)
  );

  // Transmitter model: busy for busy_len cycles starting the edge after tx_start
  always @(posedge sysclk) begin
    if (!model_on) begin
      tx_busy   <= 1'b0;
      busy_left <= 0;
    end else if (tx_start) begin
      tx_busy   <= 1'b1;
      busy_left <= busy_len - 1;
    end else if (busy_left > 0) begin
      busy_left <= busy_left - 1;
    end else begin
      tx_busy <= 1'b0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
    cyc++;
    if (busy_q && !tx_busy) fall_cyc = cyc;
    busy_q = tx_busy;
    if (tx_start) begin
      start_cyc.push_back(cyc);
      start_data.push_back(tx_data);
      start_gap.push_back(cyc - fall_cyc);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_byte(input logic [7:0] d);
    rx_data       = d;
    rx_data_valid = 1'b1;
    tick();
    rx_data_valid = 1'b0;
  endtask

  task automatic wait_starts(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (start_data.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(name, start_data.size(), n);
  endtask

  initial begin
    int base;
    int n;

    rst = 1'b1; enable = 1'b0; rx_data = 8'h00; rx_data_valid = 1'b0; clear_err = 1'b0;

    for (int i = 0; i < 16; i++) vt[i] = '{1'b1, 8'(i + 1), 1'b0, 1'b0, i + 1, 1'b0, 1'b0};
    vt[16] = '{1'b1, 8'h11, 1'b0, 1'b0, 16, 1'b1, 1'b0};
    vt[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 16, 1'b0, 1'b0};
    vt[18] = '{1'b1, 8'h99, 1'b0, 1'b1, 16, 1'b1, 1'b0};
    vt[19] = '{1'b0, 8'h00, 1'b0, 1'b1, 16, 1'b0, 1'b0};

    // Reset state
    ticks(2);
    chk("rst_count", fifo_count, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_timeout", tx_timeout, 0);
    rst = 1'b0;
    ticks(2);

    // Single byte
    model_on = 1'b1; busy_len = 20; enable = 1'b1;
    ticks(2);
    push_byte(8'hA5);
    chk("single_cnt_push", fifo_count, 1);
    chk("single_no_start_yet", tx_start, 0);
    tick();
    chk("single_start", tx_start, 1);
    chk("single_data", tx_data, 8'hA5);
    chk("single_cnt_pop", fifo_count, 0);
    tick();
    chk("single_pulse_width", tx_start, 0);
    ticks(10);
    chk("single_busy_mid", tx_busy, 1);
    chk("single_data_stable", tx_data, 8'hA5);
    ticks(30);
    chk("single_starts", start_data.size(), 1);
    chk("single_cnt_end", fifo_count, 0);
    chk("single_ovf_end", overflow, 0);
    chk("single_to_end", tx_timeout, 0);

    // Burst ordering with inter-byte gap
    busy_len = 6;
    base = start_data.size();
    for (int i = 1; i <= 5; i++) begin
      push_byte(8'(i));
      ticks(2);
    end
    wait_starts(base + 5, 500, "burst_starts");
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("burst_data_%0d", i), start_data[base + i], i + 1);
      if (i > 0) begin
        chk($sformatf("burst_period_%0d", i), start_cyc[base + i] - start_cyc[base + i - 1], busy_len + 3 + GAP);
        chk($sformatf("burst_gap_ge_%0d", i), int'(start_gap[base + i] >= GAP), 1);
      end
    end
    ticks(busy_len + GAP + 10);

    // Overflow table with enable held low, then drain
    busy_len = 4;
    enable = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      rx_data_valid = vt[i].vld;
      rx_data       = vt[i].din;
      enable        = vt[i].en;
      clear_err     = vt[i].clr;
      tick();
      chk($sformatf("vec%0d_count", i), fifo_count, vt[i].exp_cnt);
      chk($sformatf("vec%0d_overflow", i), overflow, vt[i].exp_ovf);
      chk($sformatf("vec%0d_tx_start", i), tx_start, vt[i].exp_start);
    end
    rx_data_valid = 1'b0; clear_err = 1'b0;
    base = start_data.size();
    enable = 1'b1;
    wait_starts(base + 16, 600, "drain_starts");
    ticks(busy_len + GAP + 20);
    chk("drain_no_extra", start_data.size(), base + 16);
    for (int i = 0; i < 16; i++) chk($sformatf("drain_data_%0d", i), start_data[base + i], i + 1);
    chk("drain_cnt_end", fifo_count, 0);

    // Full fifo with a push in the same cycle as the IDLE pop
    enable = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) push_byte(8'h40 + 8'(i));
    chk("fullpop_cnt_full", fifo_count, 16);
    base = start_data.size();
    enable = 1'b1;
    push_byte(8'h50);
    chk("fullpop_cnt", fifo_count, 16);
    chk("fullpop_ovf", overflow, 0);
    chk("fullpop_start", tx_start, 1);
    chk("fullpop_first", tx_data, 8'h40);
    wait_starts(base + 17, 700, "fullpop_starts");
    for (int i = 0; i < 17; i++) chk($sformatf("fullpop_data_%0d", i), start_data[base + i], 8'h40 + i);
    ticks(busy_len + GAP + 20);
    chk("fullpop_cnt_end", fifo_count, 0);

    // Busy acknowledge timeout, then recovery
    model_on = 1'b0;
    ticks(2);
    base = start_data.size();
    push_byte(8'h3C);
    wait_starts(base + 1, 10, "to_start");
    chk("to_start_data", start_data[base], 8'h3C);
    n = 0;
    while (!tx_timeout && n < 4 * ACK) begin
      tick();
      n++;
    end
    chk("to_latency", n, ACK);
    ticks(GAP + 4);
    chk("to_no_retry", start_data.size(), base + 1);
    model_on = 1'b1;
    push_byte(8'h77);
    wait_starts(base + 2, 10, "to_second_start");
    chk("to_second_data", start_data[base + 1], 8'h77);
    chk("to_sticky", tx_timeout, 1);
    ticks(busy_len + GAP + 10);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("to_cleared", tx_timeout, 0);

    // Reset while waiting for busy to fall with bytes queued
    busy_len = 20;
    enable = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(8'h61 + 8'(i));
    base = start_data.size();
    enable = 1'b1;
    wait_starts(base + 1, 10, "rstmid_start");
    ticks(3);
    chk("rstmid_busy", tx_busy, 1);
    chk("rstmid_cnt_before", fifo_count, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_cnt", fifo_count, 0);
    chk("rstmid_tx_start", tx_start, 0);
    chk("rstmid_tx_data", tx_data, 0);
    ticks(40);
    chk("rstmid_quiet", start_data.size(), base + 1);
    push_byte(8'h5A);
    wait_starts(base + 2, 10, "rstmid_new_start");
    chk("rstmid_new_data", start_data[base + 1], 8'h5A);
    ticks(30);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/uart_loop_ctrl.md
Name: uart_loop_ctrl

Overview:
- Sequences received UART bytes back out through the UART transmitter.
- Input side: byte-wide receive data plus a one-cycle valid pulse from the receiver. Each byte is buffered in a small synchronous FIFO.
- Output side: a tx_start/tx_busy handshake that launches one byte at a time, with a programmable inter-byte gap, a busy-acknowledge timeout, and sticky error flags.
- Sits between the uart receiver and uart transmitter in the loopback top level.

Parameters:
- DATA_WIDTH, 8, byte width; must match receiver and transmitter.
- FIFO_DEPTH, 16, buffer entries; power of two, >=2.
- GAP_CYCLES, 0, idle sysclk cycles inserted after each transmit completes; 0 = no gap.
- ACK_TIMEOUT, 64, cycles allowed for tx_busy to rise after tx_start; >=2.

Ports:
- sysclk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  1 = drain FIFO to transmitter; 0 = hold (still buffers).
- rx_data  in  DATA_WIDTH  byte from receiver.
- rx_data_valid  in  1  one-cycle pulse; rx_data valid in that cycle.
- tx_data  out  DATA_WIDTH  byte to transmitter; stable from tx_start until tx_busy falls.
- tx_start  out  1  one-cycle launch pulse.
- tx_busy  in  1  transmitter busy; high for the frame duration.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky; a byte was dropped because the FIFO was full.
- tx_timeout  out  1  sticky; tx_busy did not rise within ACK_TIMEOUT.
- clear_err  in  1  clears both sticky flags.

Behaviour:
- Reset (rst high at a posedge):
  - FIFO emptied, fifo_count=0, state=IDLE, all counters=0.
  - tx_start=0, tx_data=0, overflow=0, tx_timeout=0.
  - Reset mid-transmit abandons the byte; no further tx_start is issued until a new byte arrives after reset.
- FIFO write:
  - On rx_data_valid, the byte is written if not full, or if full and a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow sets. Contents are unchanged on a drop.
- FIFO order and pointers:
  - Strictly first in, first out.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop leaves fifo_count unchanged.
- Sticky flags:
  - clear_err clears both flags.
  - If a set event and clear_err occur in the same cycle, the set wins.
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE, GAP.
  - IDLE: if enable=1 and FIFO not empty, pop the head byte into the tx_data register and go to START. Otherwise stay in IDLE.
  - START: tx_start=1 for exactly this cycle; clear the timeout counter; go to WAIT_BUSY.
  - WAIT_BUSY:
    - tx_busy=1 -> go to WAIT_DONE.
    - Otherwise increment the timeout counter.
    - When the counter reaches ACK_TIMEOUT-1 without tx_busy: set tx_timeout and go to GAP. The byte is lost and not retried.
  - WAIT_DONE: tx_busy=0 -> go to GAP.
  - GAP:
    - Count GAP_CYCLES cycles, then go to IDLE.
    - If GAP_CYCLES=0, go to IDLE on the next cycle (GAP lasts one cycle).
- Latency:
  - rx_data_valid sampled at edge k while idle, enabled and the FIFO is empty -> byte written at edge k.
  - Pop at edge k+1 -> tx_start high during cycle k+2 (registered output).
- Throughput: one byte per (tx_busy duration + 3 + GAP_CYCLES) cycles at minimum.
- Effect of enable:
  - Sampled only in IDLE.
  - Deasserting enable mid-byte does not abort the current byte.
- tx_busy already high in START: WAIT_BUSY sees it on the next cycle and proceeds normally.

Decomposition:
- Shared package uart_pkg:
  - FSM state localparams: one-hot, 5 bits.
  - Default DATA_WIDTH and baud-related constants shared with the receiver and transmitter.
- One sub-module, uart_sync_fifo:
  - Parameters DATA_WIDTH and FIFO_DEPTH.
  - Ports: push/pop, full/empty, count; same sysclk/rst.
  - Registered read head, combinational read of the head entry.
  - The controller owns the FSM, counters and flags.

Test Plan:
- Single byte: enable=1, rx 0xA5 pulsed at cycle 10, model tx_busy high 20 cycles after tx_start -> tx_start pulse at cycle 12 with tx_data=0xA5, fifo_count returns to 0, flags 0.
- Burst ordering: GAP_CYCLES=4, rx 0x01..0x05 back-to-back (one per 3 cycles) -> five tx_start pulses carrying 0x01..0x05 in order. Each pulse is at least 4 idle cycles after the previous tx_busy falls.
- Overflow: enable=0, push 17 bytes with FIFO_DEPTH=16 -> fifo_count=16, overflow=1. Then enable=1 -> exactly bytes 1..16 transmitted. clear_err -> overflow=0.
- Timeout: tx_busy tied 0, push 0x3C -> tx_start once, tx_timeout=1 exactly ACK_TIMEOUT cycles later. FSM returns to IDLE and a second byte still launches.
- Full with simultaneous pop: FIFO full, rx_data_valid in the same cycle as an IDLE pop -> byte accepted, overflow stays 0, fifo_count stays 16.
- Reset mid-transmit: assert rst during WAIT_DONE with 3 bytes queued -> next cycle fifo_count=0, tx_start=0, state IDLE. No tx_start occurs until a new rx_data_valid.
